// File: rtl/cpu_pkg.sv
// Shared definitions for the 16-bit pipelined cpu.
package cpu_pkg;
  localparam int               WORD_W     = 16;
  localparam logic [3:0]       OPCODE_HLT = 4'hF;
  localparam logic [WORD_W-1:0] INSTR_NOP = 16'h0000;
  localparam logic [WORD_W-1:0] PC_RESET  = 16'h0000;

  typedef enum logic {
    FETCH_RUN    = 1'b0,
    FETCH_HALTED = 1'b1
  } fetch_state_e;

  // IF/ID pipeline register contents.
  typedef struct packed {
    logic [WORD_W-1:0] instr;
    logic [WORD_W-1:0] pcPlus2;
    logic              valid;
  } ifid_t;

  // Sequential next PC; wraps modulo 2^16.
  function automatic logic [WORD_W-1:0] pcInc(input logic [WORD_W-1:0] pc);
    return pc + WORD_W'(2);
  endfunction
endpackage

// File: rtl/pc_register.sv
// Program counter flop with next-PC select: redirect target, hold, or +2.
module pc_register
  import cpu_pkg::*;
#(
  parameter logic [WORD_W-1:0] RESET_PC = PC_RESET
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              redirect,
  input  logic [WORD_W-1:0] redirectPc,
  input  logic              hold,
  output logic [WORD_W-1:0] pc,
  output logic [WORD_W-1:0] pcPlus2
);
  logic [WORD_W-1:0] pcNext;

  assign pcPlus2 = pcInc(pc);

  // Redirect beats hold; branch targets are always halfword aligned.
  always_comb begin
    pcNext = pcPlus2;
    if (redirect)  pcNext = redirectPc & ~WORD_W'(1);
    else if (hold) pcNext = pc;
  end

  // PC state, asynchronously reset to the boot address.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pc <= RESET_PC;
    else        pc <= pcNext;
  end
endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC, IF/ID register, HLT freeze and fetch counter.
module fetch_stage
  import cpu_pkg::*;
#(
  parameter logic [WORD_W-1:0] RESET_PC   = PC_RESET,
  parameter logic [WORD_W-1:0] NOP_INSTR  = INSTR_NOP,
  parameter logic [3:0]        HLT_OPCODE = OPCODE_HLT
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic [WORD_W-1:0] imem_addr,
  input  logic [WORD_W-1:0] imem_data,
  input  logic              stall,
  input  logic              redirect,
  input  logic [WORD_W-1:0] redirect_pc,
  output logic [WORD_W-1:0] pc_out,
  output logic [WORD_W-1:0] ifid_instr,
  output logic [WORD_W-1:0] ifid_pc_plus2,
  output logic              ifid_valid,
  output logic              fetch_halted,
  output logic [WORD_W-1:0] fetch_count
);
  fetch_state_e      state, stateNext;
  ifid_t             ifid, ifidNext, bubble;
  logic [WORD_W-1:0] pc, pcPlus2;
  logic              pcHold, countInc, isHlt;

  assign isHlt  = (imem_data[15:12] == HLT_OPCODE);
  assign bubble = '{instr: NOP_INSTR, pcPlus2: '0, valid: 1'b0};

  pc_register #(.RESET_PC(RESET_PC)) uPc (
    .clk       (clk),
    .rst_n     (rst_n),
    .redirect  (redirect),
    .redirectPc(redirect_pc),
    .hold      (pcHold),
    .pc        (pc),
    .pcPlus2   (pcPlus2)
  );

  // Per-edge priority: redirect, stall, halted, normal fetch.
  always_comb begin
    stateNext = state;
    ifidNext  = ifid;
    countInc  = 1'b0;
    pcHold    = 1'b1;
    if (redirect) begin
      // Squashes whatever sat in the branch shadow, including a HLT.
      stateNext = FETCH_RUN;
      ifidNext  = bubble;
    end else if (stall) begin
      // Everything holds.
    end else if (state == FETCH_HALTED) begin
      ifidNext = bubble;
    end else begin
      ifidNext = '{instr: imem_data, pcPlus2: pcPlus2, valid: 1'b1};
      countInc = 1'b1;
      // HLT enters IF/ID once; PC parks on its address.
      if (isHlt) stateNext = FETCH_HALTED;
      else       pcHold    = 1'b0;
    end
  end

  // Halt FSM, IF/ID register and saturating fetch counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= FETCH_RUN;
      ifid        <= '{instr: NOP_INSTR, pcPlus2: '0, valid: 1'b0};
      fetch_count <= '0;
    end else begin
      state <= stateNext;
      ifid  <= ifidNext;
      if (countInc && fetch_count != '1) fetch_count <= fetch_count + WORD_W'(1);
    end
  end

  assign imem_addr     = pc;
  assign pc_out        = pc;
  assign ifid_instr    = ifid.instr;
  assign ifid_pc_plus2 = ifid.pcPlus2;
  assign ifid_valid    = ifid.valid;
  assign fetch_halted  = (state == FETCH_HALTED);
endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] imem_addr, imem_data;
  logic        stall = 1'b0, redirect = 1'b0;
  logic [15:0] redirect_pc = 16'h0;
  logic [15:0] pc_out, ifid_instr, ifid_pc_plus2, fetch_count;
  logic        ifid_valid, fetch_halted;

  int nChecks = 0;
  int nFail   = 0;

  logic [15:0] mem [0:32767];
  assign imem_data = mem[imem_addr[15:1]];

  fetch_stage dut (
    .clk(clk), .rst_n(rst_n), .imem_addr(imem_addr), .imem_data(imem_data),
    .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
    .pc_out(pc_out), .ifid_instr(ifid_instr), .ifid_pc_plus2(ifid_pc_plus2),
    .ifid_valid(ifid_valid), .fetch_halted(fetch_halted), .fetch_count(fetch_count)
  );

  always #5 clk = ~clk;

  // Reference model: architectural view of the fetch stage.
  logic [15:0] mPc, mInstr, mPp2, mCount;
  logic        mValid, mHalted;

  logic [81:0] obs;
  assign obs = {pc_out, imem_addr, ifid_instr, ifid_pc_plus2, ifid_valid, fetch_halted, fetch_count};

  function automatic logic [81:0] expVec();
    return {mPc, mPc, mInstr, mPp2, mValid, mHalted, mCount};
  endfunction

  function automatic logic [15:0] normalWord();
    logic [15:0] w;
    w = 16'($urandom);
    if (w[15:12] == 4'hF) w[15:12] = 4'h1;
    return w;
  endfunction

  task automatic modelReset();
    mPc = 16'h0; mInstr = 16'h0; mPp2 = 16'h0; mValid = 1'b0; mHalted = 1'b0; mCount = 16'h0;
  endtask

  task automatic modelEdge(input logic st, input logic rd, input logic [15:0] tgt);
    logic [15:0] w;
    if (rd) begin
      mPc = {tgt[15:1], 1'b0};
      mInstr = 16'h0; mPp2 = 16'h0; mValid = 1'b0; mHalted = 1'b0;
    end else if (st) begin
    end else if (mHalted) begin
      mInstr = 16'h0; mPp2 = 16'h0; mValid = 1'b0;
    end else begin
      w = mem[mPc[15:1]];
      mInstr = w; mPp2 = mPc + 16'd2; mValid = 1'b1;
      if (mCount != 16'hFFFF) mCount = mCount + 16'd1;
      if (w[15:12] == 4'hF) mHalted = 1'b1;
      else                  mPc = mPc + 16'd2;
    end
  endtask

  // Drive inputs, take one edge, advance the model; outputs then sampled #1 later.
  task automatic step(input logic st, input logic rd, input logic [15:0] tgt);
    stall = st; redirect = rd; redirect_pc = tgt;
    @(posedge clk); #1;
    modelEdge(st, rd, tgt);
    stall = 1'b0; redirect = 1'b0;
  endtask

  task automatic doReset();
    rst_n = 1'b0; stall = 1'b0; redirect = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    modelReset();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #2;
    modelReset();
    nChecks++;
    if (obs !== expVec()) begin
      nFail++; $display("FAIL reset: got %h want %h", obs, expVec());
    end
    doReset();
  endtask

  task automatic test_sequential();
    for (int i = 0; i < 8; i++) mem[i] = normalWord();
    doReset();
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 16'h0);
      nChecks++;
      if (obs !== expVec()) begin
        nFail++; $display("FAIL seq%0d: got %h want %h", i, obs, expVec());
      end
    end
    nChecks++;
    if (ifid_pc_plus2 !== 16'h0006 || fetch_count !== 16'd3) begin
      nFail++; $display("FAIL seq_end: pp2=%h cnt=%0d want 0006/3", ifid_pc_plus2, fetch_count);
    end
  endtask

  task automatic test_stall();
    // PC is 0x0006 after test_sequential; take it back to 0x0004 first.
    doReset();
    step(1'b0, 1'b0, 16'h0);
    step(1'b0, 1'b0, 16'h0);
    for (int i = 0; i < 2; i++) begin
      step(1'b1, 1'b0, 16'h0);
      nChecks++;
      if (obs !== expVec() || pc_out !== 16'h0004) begin
        nFail++; $display("FAIL stall%0d: got %h want %h", i, obs, expVec());
      end
    end
    step(1'b0, 1'b0, 16'h0);
    nChecks++;
    if (obs !== expVec() || pc_out !== 16'h0006) begin
      nFail++; $display("FAIL stall_resume: got %h want %h", obs, expVec());
    end
  endtask

  task automatic test_redirect_stall();
    mem[16'h0040 >> 1] = normalWord();
    step(1'b1, 1'b1, 16'h0041);
    nChecks++;
    if (obs !== expVec() || pc_out !== 16'h0040 || ifid_valid !== 1'b0) begin
      nFail++; $display("FAIL redir_stall: got %h want %h", obs, expVec());
    end
    step(1'b0, 1'b0, 16'h0);
    nChecks++;
    if (obs !== expVec() || ifid_pc_plus2 !== 16'h0042) begin
      nFail++; $display("FAIL redir_next: got %h want %h", obs, expVec());
    end
  endtask

  task automatic test_halt();
    for (int i = 0; i < 5; i++) mem[i] = normalWord();
    mem[5] = 16'hF000;
    doReset();
    for (int i = 0; i < 9; i++) begin
      step(1'b0, 1'b0, 16'h0);
      nChecks++;
      if (obs !== expVec()) begin
        nFail++; $display("FAIL halt%0d: got %h want %h", i, obs, expVec());
      end
    end
    nChecks++;
    if (pc_out !== 16'h000A || fetch_halted !== 1'b1 || fetch_count !== 16'd6 || ifid_valid !== 1'b0) begin
      nFail++; $display("FAIL halt_end: pc=%h h=%b cnt=%0d v=%b want 000A/1/6/0",
                        pc_out, fetch_halted, fetch_count, ifid_valid);
    end
  endtask

  task automatic test_shadow_and_wrap();
    mem[0] = normalWord(); mem[1] = 16'hF123;
    mem[16'h0020 >> 1] = normalWord();
    mem[16'hFFFE >> 1] = normalWord();
    doReset();
    step(1'b0, 1'b0, 16'h0);
    step(1'b0, 1'b0, 16'h0);
    nChecks++;
    if (obs !== expVec() || fetch_halted !== 1'b1) begin
      nFail++; $display("FAIL shadow_hlt: got %h want %h", obs, expVec());
    end
    step(1'b0, 1'b1, 16'h0020);
    nChecks++;
    if (obs !== expVec() || fetch_halted !== 1'b0) begin
      nFail++; $display("FAIL shadow_redir: got %h want %h", obs, expVec());
    end
    step(1'b0, 1'b0, 16'h0);
    nChecks++;
    if (obs !== expVec() || ifid_pc_plus2 !== 16'h0022) begin
      nFail++; $display("FAIL shadow_resume: got %h want %h", obs, expVec());
    end
    step(1'b0, 1'b1, 16'hFFFE);
    step(1'b0, 1'b0, 16'h0);
    nChecks++;
    if (obs !== expVec() || pc_out !== 16'h0000 || ifid_pc_plus2 !== 16'h0000) begin
      nFail++; $display("FAIL wrap: got %h want %h", obs, expVec());
    end
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 6; i++) mem[i] = normalWord();
    mem[6] = 16'hF000;
    doReset();
    for (int i = 0; i < 9; i++) step(1'b0, 1'b0, 16'h0);
    nChecks++;
    if (obs !== expVec() || fetch_count !== 16'd7 || fetch_halted !== 1'b1) begin
      nFail++; $display("FAIL pre_async: got %h want %h", obs, expVec());
    end
    #2 rst_n = 1'b0;
    #1;
    modelReset();
    nChecks++;
    if (obs !== expVec()) begin
      nFail++; $display("FAIL async_rst: got %h want %h", obs, expVec());
    end
    rst_n = 1'b1;
    step(1'b0, 1'b0, 16'h0);
    nChecks++;
    if (obs !== expVec() || ifid_pc_plus2 !== 16'h0002 || ifid_valid !== 1'b1) begin
      nFail++; $display("FAIL restart: got %h want %h", obs, expVec());
    end
  endtask

  task automatic test_random();
    logic st, rd;
    logic [15:0] tgt;
    for (int i = 0; i < 32768; i++)
      mem[i] = ($urandom_range(0, 9) == 0) ? 16'hF000 | 16'($urandom_range(0, 4095)) : normalWord();
    doReset();
    for (int i = 0; i < 600; i++) begin
      st  = ($urandom_range(0, 4) == 0);
      rd  = ($urandom_range(0, 7) == 0);
      tgt = 16'($urandom);
      step(st, rd, tgt);
      nChecks++;
      if (obs !== expVec()) begin
        nFail++; $display("FAIL rand%0d: got %h want %h", i, obs, expVec());
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 32768; i++) mem[i] = 16'h0;
    test_reset();
    test_sequential();
    test_stall();
    test_redirect_stall();
    test_halt();
    test_shadow_and_wrap();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end
endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch (IF) stage of the 16-bit, five-stage pipelined `cpu`, directly upstream of decode. It owns the program counter, drives the instruction-memory address, and loads the IF/ID pipeline register. It also detects the HLT opcode and freezes fetch, so the halt propagates once down the pipeline to the `hlt` output. It accepts stall and branch-redirect requests from decode.

## Interface
Parameters:
- `RESET_PC`, 16'h0000, PC value loaded on reset.
- `NOP_INSTR`, 16'h0000, encoding inserted into IF/ID as a bubble.
- `HLT_OPCODE`, 4'hF, value of `instr[15:12]` that marks HLT.

Ports:
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `imem_addr`  out  16  instruction-memory address; equals `pc_out`.
- `imem_data`  in  16  instruction word; combinational read of `imem_addr` in the same cycle.
- `stall`  in  1  hold PC and IF/ID (load-use hazard from decode).
- `redirect`  in  1  taken branch or jump resolved in decode.
- `redirect_pc`  in  16  target for `redirect`; bit 0 is ignored and forced to 0.
- `pc_out`  out  16  current PC.
- `ifid_instr`  out  16  IF/ID instruction.
- `ifid_pc_plus2`  out  16  IF/ID PC+2 (link/branch base).
- `ifid_valid`  out  1  IF/ID holds a real instruction.
- `fetch_halted`  out  1  fetch is frozen on HLT.
- `fetch_count`  out  16  valid instructions loaded into IF/ID; saturates at 16'hFFFF.

## Operation
- States:
  - RUN: normal fetch.
  - HALTED: a HLT has been fetched. Leaves only on `redirect` or reset.
- Per-edge priority:
  - `redirect` first.
  - then `stall`.
  - then HALTED.
  - then normal.
- `redirect`:
  - PC ← `{redirect_pc[15:1],1'b0}`.
  - IF/ID ← bubble (`NOP_INSTR`, valid 0, pc_plus2 0).
  - State ← RUN. This squashes a HLT fetched in the branch shadow.
  - Applies even when `stall` is also asserted.
- `stall` without redirect: PC, IF/ID, state and count all hold.
- HALTED, no redirect/stall: PC holds; IF/ID ← bubble each cycle.
- RUN, `imem_data[15:12]==HLT_OPCODE`:
  - IF/ID ← HLT, valid 1.
  - PC holds at the HLT's address.
  - State ← HALTED.
  - HLT enters the pipeline exactly once.
- RUN, other instruction: IF/ID ← `imem_data`, PC+2, valid 1; PC ← PC+2.
- Arithmetic: PC+2 is modulo 2^16; 16'hFFFE wraps to 16'h0000.
- `fetch_count` increments on every edge that writes IF/ID with valid 1, including HLT. It holds at 16'hFFFF.
- `fetch_halted` = (state==HALTED).

## Timing
- Reset values:
  - `pc_out`/`imem_addr` = `RESET_PC`.
  - `ifid_instr` = `NOP_INSTR`, `ifid_pc_plus2` = 0, `ifid_valid` = 0.
  - `fetch_halted` = 0, `fetch_count` = 0, state RUN.
- Reset asserted mid-operation returns all state immediately (asynchronously) to the reset values.
- First fetch is from `RESET_PC` in the cycle after `rst_n` rises. The IF/ID valid appears one edge later.
- Fetch latency: an instruction addressed in cycle N appears on `ifid_*` after edge N+1.
- Redirect penalty: exactly one bubble. The target is fetched in the cycle after the redirect edge.
- `stall` and `redirect` are sampled only at the rising edge. They have no combinational path to `imem_addr` or `pc_out`.

## Structure
- Shared package `cpu_pkg` holds:
  - `WORD_W` = 16.
  - `OPCODE_HLT` = 4'hF.
  - `INSTR_NOP` = 16'h0000.
  - the fetch state enum (`FETCH_RUN`, `FETCH_HALTED`).
- Parameter defaults take their values from the package.
- One sub-module, `pc_register`, holds the PC flop plus next-PC mux (redirect / hold / +2) and reset value.
- IF/ID register, halt FSM and counter live in `fetch_stage`.

## Test plan
- Reset then sequential fetch of ADD words at 0x0000, 0x0002, 0x0004 → `ifid_instr` follows memory one cycle late; `ifid_pc_plus2` = 0x0002, 0x0004, 0x0006; `fetch_count` = 3.
- `stall` high for 2 cycles at PC 0x0004 → `pc_out` stays 0x0004; `ifid_*` and `fetch_count` unchanged; fetch resumes at 0x0006.
- `redirect`=1 with `redirect_pc`=0x0041 and `stall`=1 on the same edge → `pc_out`=0x0040; `ifid_valid`=0 for one cycle; next instruction has `ifid_pc_plus2`=0x0042.
- HLT (0xF000) at 0x000A → IF/ID holds 0xF000 with valid 1 once; then only bubbles; `pc_out` stays 0x000A; `fetch_halted`=1; `fetch_count` frozen.
- HLT fetched in the shadow, then `redirect` to 0x0020 on the next edge → `fetch_halted` returns to 0; fetch resumes at 0x0020. Separately: PC at 0xFFFE, normal fetch → `pc_out` wraps to 0x0000.
- `rst_n` dropped asynchronously mid-cycle while HALTED with `fetch_count`=7 → outputs go to reset values before the next edge; fetch restarts at `RESET_PC`.
